// File: rtl/rr_mux4_arb_pkg.sv
// Shared types and the round-robin pick function for the rr_mux4_arbiter block.
package rr_mux4_arb_pkg;

    localparam int NUM_REQ = 4;
    localparam int SEL_W   = 2;

    typedef enum logic {
        S_IDLE,
        S_GRANT
    } arb_state_t;

    // Scans ptr+1, ptr+2, ptr+3, ptr (mod 4) and returns the first valid index.
    // Returns ptr when nothing is valid; callers only use the result when |valid.
    function automatic logic [SEL_W-1:0] rr_pick(
        input logic [NUM_REQ-1:0] valid,
        input logic [SEL_W-1:0]   ptr
    );
        logic [SEL_W-1:0] idx;
        logic             found;
        rr_pick = ptr;
        found   = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = ptr + SEL_W'(k);
            if (!found && valid[idx]) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/rr_mux4_arbiter_mux4.sv
// Plain 4:1 mux over a packed {w3,w2,w1,w0} bus of N-bit words.
module mux4
    import rr_mux4_arb_pkg::*;
#(
    parameter int N = 1
) (
    input  logic [NUM_REQ*N-1:0] i_d,
    input  logic [SEL_W-1:0]     i_sel,
    output logic [N-1:0]         o_y
);

    assign o_y = i_d[i_sel*N +: N];

endmodule

// File: rtl/rr_mux4_arbiter.sv
// Round-robin arbiter for four valid/ready requesters sharing one mux4 datapath.
// Define RR_MUX4_ARB_PKT_LOCK_EN to hold the grant until a beat with out_last=1 transfers.
module rr_mux4_arbiter
    import rr_mux4_arb_pkg::*;
#(
    parameter int N = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [NUM_REQ*N-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 out_valid,
    output logic [N-1:0]         out_data,
    output logic                 out_last,
    input  logic                 out_ready,
    output logic [SEL_W-1:0]     sel,
    output logic                 busy
);

    arb_state_t                 r_state;
    arb_state_t                 w_state_nxt;
    logic [SEL_W-1:0]           r_sel;
    logic [SEL_W-1:0]           r_ptr;
    logic [SEL_W-1:0]           w_sel_nxt;
    logic [SEL_W-1:0]           w_ptr_nxt;
    logic [SEL_W-1:0]           w_winner;
    logic                       w_transfer;
    logic                       w_release;
    logic [NUM_REQ*(N+1)-1:0]   w_mux_in;
    logic [N:0]                 w_mux_out;

    // last rides alongside data so one mux instance serves both.
    always_comb begin
        w_mux_in = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_mux_in[i*(N+1) +: N+1] = {req_last[i], req_data[i*N +: N]};
        end
    end

    mux4 #(
        .N (N + 1)
    ) u_mux4 (
        .i_d   (w_mux_in),
        .i_sel (r_sel),
        .o_y   (w_mux_out)
    );

    assign {out_last, out_data} = w_mux_out;

    assign busy      = (r_state == S_GRANT);
    assign sel       = r_sel;
    assign out_valid = busy & req_valid[r_sel];
    assign w_winner  = rr_pick(req_valid, r_ptr);

    always_comb begin
        req_ready = '0;
        if (busy) begin
            req_ready[r_sel] = out_ready;
        end
    end

    assign w_transfer = out_valid & out_ready;

`ifdef RR_MUX4_ARB_PKT_LOCK_EN
    assign w_release = w_transfer & out_last;
`else
    assign w_release = w_transfer;
`endif

    // NOTE: every output of a combinational block gets a default first; a path
    // that leaves one unassigned would infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_sel_nxt   = r_sel;
        w_ptr_nxt   = r_ptr;
        case (r_state)
            S_IDLE: begin
                if (|req_valid) begin
                    w_sel_nxt   = w_winner;
                    w_ptr_nxt   = w_winner;
                    w_state_nxt = S_GRANT;
                end
            end
            S_GRANT: begin
                if (w_release) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_sel   <= '0;
            r_ptr   <= SEL_W'(NUM_REQ - 1);
        end else begin
            r_state <= w_state_nxt;
            r_sel   <= w_sel_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

endmodule
